// File: rtl/prf_free_list_if.sv
// prf_free_list_if: allocate/free handshake between rename, commit and the physical-register free list
interface prf_free_list_if #(
  parameter int NUM_PHYS = 64,
  parameter int DEPTH    = 32
);
  localparam int TW = $clog2(NUM_PHYS);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          alloc_req_i;
  logic [TW-1:0] alloc_prd_o;
  logic          alloc_valid_o;
  logic          free_req_i;
  logic [TW-1:0] free_prd_i;
  logic          empty_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          err_o;
  modport slave (
    input  alloc_req_i, free_req_i, free_prd_i,
    output alloc_prd_o, alloc_valid_o, empty_o, full_o, count_o, err_o
  );
  modport master (
    output alloc_req_i, free_req_i, free_prd_i,
    input  alloc_prd_o, alloc_valid_o, empty_o, full_o, count_o, err_o
  );
endinterface

// File: rtl/prf_free_list.sv
// prf_free_list: circular FIFO of free physical tags plus a free bitmap that rejects illegal frees
module prf_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int DEPTH    = 32
) (
  input logic           clk_i,
  input logic           reset_i,
  prf_free_list_if.slave fl
);
  localparam int TW = $clog2(NUM_PHYS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [TW-1:0]       entry [DEPTH];
  logic [NUM_PHYS-1:0] free_map;
  logic [PW-1:0]       head, tail;
  logic [CW-1:0]       count;
  logic                err, full, pop, cand, accept;
  always_comb begin
    full             = count == CW'(DEPTH);
    pop              = fl.alloc_req_i && count != '0;
    cand             = fl.free_req_i && fl.free_prd_i != '0;
    // a tag still in the FIFO (including the one popping now) has its bit set, so it is a duplicate
    accept           = cand && !free_map[fl.free_prd_i] && (!full || pop);
    fl.alloc_prd_o   = entry[head];
    fl.alloc_valid_o = count != '0;
    fl.empty_o       = count == '0;
    fl.full_o        = full;
    fl.count_o       = count;
    fl.err_o         = err;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= TW'(NUM_ARCH + i);
      free_map <= {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
      head     <= '0;
      tail     <= '0;
      count    <= CW'(DEPTH);
      err      <= 1'b0;
    end else begin
      if (pop) begin
        head                  <= head + 1'b1;
        free_map[entry[head]] <= 1'b0;
      end
      if (accept) begin
        entry[tail]              <= fl.free_prd_i;
        tail                     <= tail + 1'b1;
        free_map[fl.free_prd_i] <= 1'b1;
      end
      count <= count + CW'(accept) - CW'(pop);
      err   <= err | (cand && !accept);
    end
  end
endmodule

// File: tb/tb_prf_free_list.sv
// tb_prf_free_list: directed scenarios plus random traffic checked against a queue-based model
module tb_prf_free_list;
  localparam int DEPTH = 32;
  logic clk_i = 0, reset_i = 1;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  bit err_m;
  prf_free_list_if #(.NUM_PHYS(64), .DEPTH(DEPTH)) fl ();
  prf_free_list #(.NUM_PHYS(64), .NUM_ARCH(32), .DEPTH(DEPTH)) dut (.clk_i(clk_i), .reset_i(reset_i), .fl(fl));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1;
    return 0;
  endfunction
  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
    err_m = 0;
  endfunction
  task automatic step(input bit r, input bit a, input bit f, input int p);
    bit pop, acc;
    int tag;
    reset_i = r;
    fl.alloc_req_i = a;
    fl.free_req_i = f;
    fl.free_prd_i = 6'(p);
    @(negedge clk_i);
    check("valid", int'(fl.alloc_valid_o), int'(q.size() != 0));
    if (q.size() != 0) check("prd", int'(fl.alloc_prd_o), q[0]);
    check("count", int'(fl.count_o), q.size());
    check("empty", int'(fl.empty_o), int'(q.size() == 0));
    check("full", int'(fl.full_o), int'(q.size() == DEPTH));
    check("err", int'(fl.err_o), int'(err_m));
    @(posedge clk_i);
    if (r) model_reset();
    else begin
      pop = a && q.size() != 0;
      tag = pop ? q[0] : -1;
      acc = f && p != 0 && !in_q(p) && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(p);
      if (f && p != 0 && !acc) err_m = 1;
    end
    #1;
  endtask
  initial begin
    int held[$];
    fl.alloc_req_i = 0;
    fl.free_req_i = 0;
    fl.free_prd_i = 0;
    @(posedge clk_i);
    #1;
    model_reset();
    // drain all 32 tags in order, then free into an empty list with and without a request
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 45);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 40);
    step(0, 0, 0, 0);
    // legal free then duplicate
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32);
    step(0, 0, 1, 32);
    step(0, 0, 0, 0);
    // p0 dropped silently, then free while full without a pop
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 5);
    step(0, 0, 0, 0);
    step(0, 1, 1, 6);
    step(0, 0, 0, 0);
    // freeing the tag being popped this cycle
    step(1, 0, 0, 0);
    step(0, 1, 1, 32);
    step(0, 0, 0, 0);
    // half-full steady state across pointer wrap, then reset mid-stream
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      held.push_back(32 + i);
      step(0, 1, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      held.push_back(q[0]);
      step(0, 1, 1, held.pop_front());
    end
    step(1, 1, 1, held[0]);
    step(0, 0, 0, 0);
    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      int p;
      bit r, a, f;
      r = $urandom_range(0, 149) == 0;
      a = $urandom_range(0, 99) < 55;
      f = $urandom_range(0, 99) < 50;
      p = $urandom_range(0, 63);
      if ($urandom_range(0, 9) < 8)
        for (int k = 0; k < 64 && in_q(p); k++) p = $urandom_range(1, 63);
      else if ($urandom_range(0, 3) == 0 && q.size() != 0) p = q[0];
      step(r, a, f, p);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
